// File: rtl/ex_stage_pkg.sv
// Shared ALU operation encodings and datapath widths, used by the ALU control
// decoder and the execute stage.
package ex_stage_pkg;

    localparam int W  = 32;
    localparam int RW = 5;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_ADDU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SUBU = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;

endpackage

// File: rtl/ex_stage_alu_core.sv
// Combinational ALU. Signed-overflow detection exists only when
// ALU_OVF_TRAP_EN is defined; otherwise ovf_raw is tied low.
module alu_core #(
    parameter int W = ex_stage_pkg::W
) (
    input  logic [3:0]   aluc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   sa,
    output logic [W-1:0] y,
    output logic         ovf_raw
);
    import ex_stage_pkg::*;

    logic [W-1:0] add_s;
    logic [W-1:0] sub_s;

    assign add_s = a + b;
    assign sub_s = a - b;

    // Result selection by operation code
    always_comb begin
        y = {W{1'b0}};
        case (aluc)
            ALU_ADD, ALU_ADDU: y = add_s;
            ALU_SUB, ALU_SUBU: y = sub_s;
            ALU_AND:           y = a & b;
            ALU_OR:            y = a | b;
            ALU_XOR:           y = a ^ b;
            ALU_NOR:           y = ~(a | b);
            ALU_SLT:           y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:          y = {{(W-1){1'b0}}, (a < b)};
            ALU_SLL:           y = b << sa;
            ALU_SRL:           y = b >> sa;
            ALU_SRA:           y = $signed(b) >>> sa;
            default:           y = {W{1'b0}};
        endcase
    end

`ifdef ALU_OVF_TRAP_EN
    // Signed overflow: only the trapping ADD/SUB forms can flag
    always_comb begin
        ovf_raw = 1'b0;
        case (aluc)
            ALU_ADD: ovf_raw = (a[W-1] == b[W-1]) && (add_s[W-1] != a[W-1]);
            ALU_SUB: ovf_raw = (a[W-1] != b[W-1]) && (sub_s[W-1] != a[W-1]);
            default: ovf_raw = 1'b0;
        endcase
    end
`else
    assign ovf_raw = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: shift-amount select, ALU, trap gating and the EX/MEM register.
// Optional signed-overflow trap enabled by defining ALU_OVF_TRAP_EN.
module ex_stage #(
    parameter int W  = ex_stage_pkg::W,
    parameter int RW = ex_stage_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [3:0]    aluc,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [4:0]    shamt,
    input  logic          use_shamt,
    input  logic [RW-1:0] rd,
    input  logic          wreg,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [W-1:0]  result,
    output logic [RW-1:0] out_rd,
    output logic          out_wreg,
    output logic          zero,
    output logic          ovf
);
    import ex_stage_pkg::*;

    logic [4:0]   sa_s;
    logic [W-1:0] y_s;
    logic         ovf_raw_s;
    logic         trap_s;

    assign sa_s = use_shamt ? shamt : a[4:0];

    alu_core #(.W(W)) u_alu_core (
        .aluc    (aluc),
        .a       (a),
        .b       (b),
        .sa      (sa_s),
        .y       (y_s),
        .ovf_raw (ovf_raw_s)
    );

    // A bubble never traps, so overflow is qualified by the slot being real
    assign trap_s = ovf_raw_s & in_valid;

    // EX/MEM register: reset, then flush, then stall, then load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= {W{1'b0}};
            out_rd    <= {RW{1'b0}};
            out_wreg  <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            result    <= {W{1'b0}};
            out_rd    <= {RW{1'b0}};
            out_wreg  <= 1'b0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
        end else if (stall) begin
            out_valid <= out_valid;
            result    <= result;
            out_rd    <= out_rd;
            out_wreg  <= out_wreg;
            zero      <= zero;
            ovf       <= ovf;
        end else begin
            out_valid <= in_valid;
            result    <= y_s;
            out_rd    <= rd;
            out_wreg  <= wreg & in_valid & ~trap_s;
            zero      <= (y_s == {W{1'b0}});
            ovf       <= trap_s;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline. Consumes the 4-bit ALU operation code produced by the ALU control decoder, together with the forwarded operands from ID/EX. Computes the ALU result and registers it, with destination and control bits, into the EX/MEM pipeline register. Also handles pipeline stall/flush and an optional signed-overflow trap.

## Interface
Parameters:
- `W`, 32, datapath width
- `RW`, 5, register-index width

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  synchronous reset, active low
- `in_valid`  in  1  ID/EX slot holds a real instruction
- `aluc`  in  4  ALU operation code; encodings are the shared `ALU_*` header constants
- `a`  in  W  operand A (rs, post-forwarding)
- `b`  in  W  operand B (rt or extended immediate)
- `shamt`  in  5  instruction shift-amount field
- `use_shamt`  in  1  1: shift by `shamt`; 0: shift by `a[4:0]` (variable shifts)
- `rd`  in  RW  destination register index
- `wreg`  in  1  instruction writes a register
- `stall`  in  1  hold EX/MEM contents
- `flush`  in  1  load a bubble into EX/MEM
- `out_valid`  out  1  EX/MEM slot valid
- `result`  out  W  registered ALU result
- `out_rd`  out  RW  registered destination
- `out_wreg`  out  1  registered write enable (already gated by `in_valid` and the overflow trap)
- `zero`  out  1  registered `result == 0`
- `ovf`  out  1  registered signed-overflow flag

## Operation
Combinational result, by `aluc`:
- ADD/ADDU: a+b. SUB/SUBU: a−b. Both modulo 2^W.
- AND/OR/XOR/NOR: bitwise.
- SLT: 1 if signed a<b, else 0. SLTU: same comparison, unsigned.
- SLL/SRL/SRA: shift `b` by the shift amount. SRA replicates b[W-1].
- Shift amount: `shamt` if `use_shamt`, else `a[4:0]`. Shifts of 0 pass `b` unchanged.
- Any other code: result 0.

Signed overflow is computed for ADD and SUB only:
- ADD: operands have the same sign and the result sign differs.
- SUB: operands have different signs and the result sign differs from a.
- ADDU/SUBU never flag overflow.

Register update priority, each rising edge:
1. `rst_n`=0: all outputs cleared to 0.
2. else `flush`: bubble loaded. `out_valid`, `out_wreg`, `ovf` = 0; `result`, `out_rd` = 0; `zero` = 1.
3. else `stall`: all outputs hold.
4. else load: `out_valid`=`in_valid`, `result`, `zero`, `out_rd`, `ovf`, and `out_wreg` = `wreg` & `in_valid` & ~trap.

Further rules:
- When `in_valid`=0 on load, `out_wreg`=0 and `ovf`=0. `result` and `out_rd` are still loaded, as don't-care values.
- Flush and stall asserted together: flush wins.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- The datapath is combinational from inputs to the register D-side; there is no internal state other than EX/MEM.
- Reset values: every output 0, including `zero`. Reset is synchronous, so outputs change only on an edge with `rst_n`=0.
- Reset asserted mid-stall clears the register. Stall released on the same edge as reset deassertion loads normally on the next edge.
- Stall held for k cycles: outputs are constant for k edges. Inputs during a stall are ignored; upstream is responsible for holding them.

## Configuration
- `ALU_OVF_TRAP_EN` defined:
  - `ovf` reflects signed overflow of ADD/SUB.
  - On overflow, `out_wreg` is forced to 0 (write suppressed). `result` still carries the wrapped value, for EPC/debug use.
- Undefined:
  - `ovf` is constant 0 and the overflow logic is not synthesised.
  - `out_wreg` = `wreg` & `in_valid`.

## Structure
- `ALU_*` operation encodings and the widths `W`/`RW` stay in the shared header, used by both the ALU control decoder and this stage. No new encodings are introduced here.
- One sub-module: `alu_core`, purely combinational. Inputs `aluc`, `a`, `b`, `sa`; outputs `y`, `ovf_raw`.
- `ex_stage` contains the shift-amount mux, the trap gating, and the EX/MEM register.

## Test plan
- Reset: `rst_n`=0 for 2 edges with `in_valid`=1, ADD 5+3 → all outputs 0. First load after release → `result`=8, `out_valid`=1.
- Overflow, with macro: ADD 0x7FFFFFFF+1, `wreg`=1 → `result`=0x80000000, `ovf`=1, `out_wreg`=0. Same operands with ADDU → `ovf`=0, `out_wreg`=1. Without macro, ADD → `ovf`=0, `out_wreg`=1.
- Shifts: SRA, b=0x80000000, `use_shamt`=1, `shamt`=4 → 0xF8000000. `use_shamt`=0, a=36 → amount 4, same result. SLL by 0 → b unchanged.
- Compare: a=0xFFFFFFFF, b=1 → SLT → 1; SLTU → 0. SUB 7−7 → `result`=0, `zero`=1.
- Stall/flush: load OR 0xF0|0x0F (`result`=0xFF), then `stall` 2 cycles with new inputs → `result` stays 0xFF. Then `stall`=`flush`=1 → `out_valid`=0, `out_wreg`=0, `zero`=1.
- Bubble input: `in_valid`=0, `wreg`=1, ADD overflow operands → `out_valid`=0, `out_wreg`=0, `ovf`=0.
